// File: rtl/comms_xfer_scheduler_if.sv
// comms_xfer_scheduler_if: requester/serializer bus of the link scheduler; master drives requests and link status, slave is the scheduler
interface comms_xfer_scheduler_if #(parameter int WIDTH = 256);
  logic req_a, req_b, peer_ready, tx_done;
  logic [WIDTH-1:0] data_a, data_b, tx_data;
  logic grant_a, grant_b, start_tx, busy, done, err;
  logic [3:0] retry_cnt;
  modport master (
    output req_a, data_a, req_b, data_b, peer_ready, tx_done,
    input  grant_a, grant_b, start_tx, tx_data, busy, done, err, retry_cnt
  );
  modport slave (
    input  req_a, data_a, req_b, data_b, peer_ready, tx_done,
    output grant_a, grant_b, start_tx, tx_data, busy, done, err, retry_cnt
  );
endinterface

// File: rtl/comms_xfer_scheduler.sv
// comms_xfer_scheduler: round-robin shares the serial link between A and B, pulses start, supervises completion with timeout and retry
// Ports: clk, rst (sync, active high); bus.slave carries req_a/data_a, req_b/data_b,
// peer_ready, tx_done in and grant_a, grant_b, start_tx, tx_data, busy, done, err, retry_cnt out.
module comms_xfer_scheduler #(
  parameter int WIDTH     = 256,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 3
) (
  input logic clk,
  input logic rst,
  comms_xfer_scheduler_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [1:0] IDLE = 2'd0, WAIT_PEER = 2'd1, START = 2'd2, XFER = 2'd3;
  logic [1:0] state;
  logic [TW-1:0] timer;
  logic last_b, pick_a, expire, can_retry;
  always_comb begin
    pick_a    = bus.req_a & (~bus.req_b | last_b);
    // tx_done beats a coinciding timeout, and peer_ready beats one in WAIT_PEER
    expire    = timer == TW'(TIMEOUT - 1) &&
                ((state == WAIT_PEER && !bus.peer_ready) || (state == XFER && !bus.tx_done));
    can_retry = bus.retry_cnt != 4'(MAX_RETRY);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      last_b        <= 1'b1;
      bus.grant_a   <= 1'b0;
      bus.grant_b   <= 1'b0;
      bus.start_tx  <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.tx_data   <= '0;
      bus.retry_cnt <= '0;
    end else begin
      bus.grant_a  <= 1'b0;
      bus.grant_b  <= 1'b0;
      bus.start_tx <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      if (expire) begin
        if (can_retry) begin
          bus.retry_cnt <= bus.retry_cnt + 4'd1;
          timer         <= '0;
          state         <= WAIT_PEER;
        end else begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.err  <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: if (bus.req_a | bus.req_b) begin
            state         <= WAIT_PEER;
            bus.busy      <= 1'b1;
            bus.grant_a   <= pick_a;
            bus.grant_b   <= ~pick_a;
            last_b        <= ~pick_a;
            bus.tx_data   <= pick_a ? bus.data_a : bus.data_b;
            bus.retry_cnt <= '0;
            timer         <= '0;
          end
          WAIT_PEER: if (bus.peer_ready) begin
            state        <= START;
            bus.start_tx <= 1'b1;
          end else timer <= timer + 1'b1;
          START: begin
            state <= XFER;
            timer <= '0;
          end
          default: if (bus.tx_done) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else timer <= timer + 1'b1;
        endcase
      end
    end
  end
endmodule
